irq_mailbox: RTL and testbench

Interrupt message source sitting directly upstream of armv4core's interrupt inputs (i_irq, i_irq_r0, i_irq_r1). Peripherals post 64-bit messages (r0, r1) over a valid/ready port. Messages are queued in a small FIFO and delivered one at a time as a fixed-width irq pulse with stable payload, spaced so the core can take each interrupt.

---
 rtl/irq_mailbox_pkg.sv | 23 ++
 rtl/irq_fifo.sv | 72 +++++++
 rtl/irq_mailbox.sv | 144 ++++++++++++++
 tb/tb_irq_mailbox.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_mailbox_pkg.sv
// ----------------------------------------------------------------------------
// irq_mailbox_pkg
// Shared definitions for the interrupt mailbox: message width, the message
// layout as seen by the FIFO, and the delivery FSM state encodings.
// No ports (package).
// ----------------------------------------------------------------------------
package irq_mailbox_pkg;

    localparam int MSG_W = 64;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PULSE = 2'd1,
        IRQ_GAP   = 2'd2
    } irq_state_e;

    // r1 occupies the upper half so {r1, r0} concatenation maps directly.
    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r0;
    } irq_msg_t;

endpackage

// File: rtl/irq_fifo.sv
// ----------------------------------------------------------------------------
// irq_fifo
// Synchronous show-ahead FIFO holding pending interrupt messages.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : write / read requests (ignored when full / empty)
//   wdata      : message to write
//   rdata      : head entry, valid whenever empty is low
//   full,empty : registered status flags
//   count      : number of stored entries
// ----------------------------------------------------------------------------
module irq_fifo
    import irq_mailbox_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [MSG_W-1:0] wdata,
    output logic [MSG_W-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [MSG_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_n;
    logic [AW:0]      rd_ptr_n;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even if a pop happens on the same edge (no bypass).
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            empty  <= (wr_ptr_n == rd_ptr_n);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/irq_mailbox.sv
// ----------------------------------------------------------------------------
// irq_mailbox
// Queues 64-bit interrupt messages from peripherals and delivers them one at
// a time to the core as a fixed-length irq pulse with a stable payload,
// followed by a forced idle gap.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   en                      : core enable; gates pulse launch only
//   i_req_valid/o_req_ready : message handshake (ready == !full)
//   i_req_r0, i_req_r1      : message payload
//   o_irq, o_irq_r0/_r1     : interrupt pulse and payload to the core
//   o_pending               : queued messages, excluding the one in flight
//   o_busy                  : high while a pulse or gap is running
// ----------------------------------------------------------------------------
module irq_mailbox
    import irq_mailbox_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int PULSE_LEN = 10,
    parameter  int GAP_LEN   = 16,
    parameter  int CNT_W     = 8,
    localparam int PW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [31:0]   i_req_r0,
    input  logic [31:0]   i_req_r1,
    output logic          o_irq,
    output logic [31:0]   o_irq_r0,
    output logic [31:0]   o_irq_r1,
    output logic [PW-1:0] o_pending,
    output logic          o_busy
);

    irq_state_e       state;
    irq_state_e       state_n;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic             irq_n;
    logic [31:0]      r0_n;
    logic [31:0]      r1_n;
    logic             busy_n;
    logic [PW-1:0]    pending_n;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PW-1:0]    fifo_count;
    logic             push_ok;
    logic             pop;
    irq_msg_t         head;

    assign o_req_ready = !fifo_full;
    assign push_ok     = i_req_valid && !fifo_full;

    irq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({i_req_r1, i_req_r0}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal written here is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        timer_n = timer;
        irq_n   = o_irq;
        r0_n    = o_irq_r0;
        r1_n    = o_irq_r1;
        pop     = 1'b0;

        case (state)
            IRQ_IDLE: begin
                if (en && !fifo_empty) begin
                    pop     = 1'b1;
                    irq_n   = 1'b1;
                    r0_n    = head.r0;
                    r1_n    = head.r1;
                    timer_n = CNT_W'(PULSE_LEN - 1);
                    state_n = IRQ_PULSE;
                end
            end
            IRQ_PULSE: begin
                if (timer == '0) begin
                    irq_n = 1'b0;
                    if (GAP_LEN > 0) begin
                        timer_n = CNT_W'(GAP_LEN - 1);
                        state_n = IRQ_GAP;
                    end else begin
                        state_n = IRQ_IDLE;
                    end
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            IRQ_GAP: begin
                if (timer == '0) begin
                    state_n = IRQ_IDLE;
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            default: begin
                state_n = IRQ_IDLE;
            end
        endcase

        busy_n    = (state_n != IRQ_IDLE);
        // Tracks the FIFO occupancy after this edge; the launched message is
        // already popped, so it is excluded automatically.
        pending_n = fifo_count + PW'(push_ok) - PW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IRQ_IDLE;
            timer     <= '0;
            o_irq     <= 1'b0;
            o_irq_r0  <= '0;
            o_irq_r1  <= '0;
            o_pending <= '0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            o_irq     <= irq_n;
            o_irq_r0  <= r0_n;
            o_irq_r1  <= r1_n;
            o_pending <= pending_n;
            o_busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_irq_mailbox.sv
// ----------------------------------------------------------------------------
// tb_irq_mailbox
// Directed bench for irq_mailbox with default parameters (DEPTH=4,
// PULSE_LEN=10, GAP_LEN=16). Inputs are driven and outputs sampled on the
// falling clock edge; rising edges are the active edges of the design.
// ----------------------------------------------------------------------------
module tb_irq_mailbox;

    localparam int DEPTH     = 4;
    localparam int PULSE_LEN = 10;
    localparam int GAP_LEN   = 16;
    localparam int CNT_W     = 8;
    localparam int PW        = $clog2(DEPTH + 1);
    // Low cycles between one pulse's fall and the next launch: gap plus the
    // relaunch edge.
    localparam int RELAUNCH  = GAP_LEN + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [31:0]   i_req_r0 = '0;
    logic [31:0]   i_req_r1 = '0;
    logic          o_irq;
    logic [31:0]   o_irq_r0;
    logic [31:0]   o_irq_r1;
    logic [PW-1:0] o_pending;
    logic          o_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_mailbox #(
        .DEPTH     (DEPTH),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_r0    (i_req_r0),
        .i_req_r1    (i_req_r1),
        .o_irq       (o_irq),
        .o_irq_r0    (o_irq_r0),
        .o_irq_r1    (o_irq_r1),
        .o_pending   (o_pending),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offers one message and holds valid until it is accepted on a rising edge.
    task automatic push(input logic [31:0] r0, input logic [31:0] r1);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_r0    = r0;
        i_req_r1    = r1;
        while (!o_req_ready && n < 200) begin
            step();
            n++;
        end
        check("push_ready", 64'(o_req_ready), 64'd1);
        step();
        i_req_valid = 1'b0;
    endtask

    // Waits for a launch, checks payload and pulse shape; returns how many
    // cycles were waited and o_pending seen in the first pulse cycle.
    task automatic wait_pulse(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              output int wait_cyc, output int pend);
        int len = 0;
        bit stable = 1'b1;
        wait_cyc = 0;
        while (!o_irq && wait_cyc < 1000) begin
            step();
            wait_cyc++;
        end
        check({tag, "_launch"}, 64'(o_irq), 64'd1);
        pend = int'(o_pending);
        check({tag, "_r0"}, 64'(o_irq_r0), 64'(e0));
        check({tag, "_r1"}, 64'(o_irq_r1), 64'(e1));
        while (o_irq && len < 100) begin
            if (o_irq_r0 !== e0 || o_irq_r1 !== e1) stable = 1'b0;
            len++;
            step();
        end
        check({tag, "_len"}, 64'(len), 64'(PULSE_LEN));
        check({tag, "_stable"}, 64'(stable), 64'd1);
        check({tag, "_held_r0"}, 64'(o_irq_r0), 64'(e0));
    endtask

    // Counts cycles until o_busy drops (bounded).
    task automatic drain(output int n);
        n = 0;
        while (o_busy && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        int wc;
        int pd;
        int n;
        bit saw;
        logic [31:0] m0 [5];
        logic [31:0] m1 [5];
        int exp_pend [5];

        // ---------------- reset ----------------
        #12;
        check("rst_irq", 64'(o_irq), 64'd0);
        check("rst_r0", 64'(o_irq_r0), 64'd0);
        check("rst_r1", 64'(o_irq_r1), 64'd0);
        check("rst_pending", 64'(o_pending), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(o_req_ready), 64'd1);
        step();

        // ---------------- single message ----------------
        en = 1'b1;
        push(32'h0123_4567, 32'h89AB_CDEF);
        check("t1_pend_after_push", 64'(o_pending), 64'd1);
        wait_pulse("t1", 32'h0123_4567, 32'h89AB_CDEF, wc, pd);
        check("t1_latency", 64'(wc), 64'd1);
        check("t1_pend_launch", 64'(pd), 64'd0);
        drain(n);
        check("t1_gap", 64'(n), 64'(GAP_LEN));
        check("t1_pend_end", 64'(o_pending), 64'd0);
        check("t1_payload_idle", 64'(o_irq_r1), 64'h89AB_CDEF);

        // ---------------- back-to-back A, B, C ----------------
        en = 1'b0;
        push(32'hAAAA_0001, 32'hA1A1_A1A1);
        push(32'hBBBB_0002, 32'hB2B2_B2B2);
        push(32'hCCCC_0003, 32'hC3C3_C3C3);
        check("t2_pend_queued", 64'(o_pending), 64'd3);
        en = 1'b1;
        wait_pulse("t2_a", 32'hAAAA_0001, 32'hA1A1_A1A1, wc, pd);
        check("t2_a_wait", 64'(wc), 64'd1);
        check("t2_a_pend", 64'(pd), 64'd2);
        wait_pulse("t2_b", 32'hBBBB_0002, 32'hB2B2_B2B2, wc, pd);
        check("t2_b_wait", 64'(wc), 64'(RELAUNCH));
        check("t2_b_pend", 64'(pd), 64'd1);
        wait_pulse("t2_c", 32'hCCCC_0003, 32'hC3C3_C3C3, wc, pd);
        check("t2_c_wait", 64'(wc), 64'(RELAUNCH));
        check("t2_c_pend", 64'(pd), 64'd0);
        drain(n);

        // ---------------- full / backpressure ----------------
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m0[i] = 32'h5000_0000 + 32'(i);
            m1[i] = 32'h6000_0000 + 32'(i * 16);
        end
        exp_pend = '{3, 3, 2, 1, 0};
        for (int i = 0; i < 4; i++) push(m0[i], m1[i]);
        check("t3_full_ready", 64'(o_req_ready), 64'd0);
        check("t3_full_pend", 64'(o_pending), 64'd4);
        i_req_valid = 1'b1;
        i_req_r0    = m0[4];
        i_req_r1    = m1[4];
        repeat (5) step();
        check("t3_blocked_pend", 64'(o_pending), 64'd4);
        check("t3_blocked_ready", 64'(o_req_ready), 64'd0);
        en = 1'b1;
        step();
        // Launch edge pops while full: the held push must not bypass.
        check("t3_launch_irq", 64'(o_irq), 64'd1);
        check("t3_launch_pend", 64'(o_pending), 64'd3);
        check("t3_launch_ready", 64'(o_req_ready), 64'd1);
        check("t3_launch_r0", 64'(o_irq_r0), 64'(m0[0]));
        step();
        i_req_valid = 1'b0;
        check("t3_fifth_accepted", 64'(o_pending), 64'd4);
        n = 0;
        while (o_irq && n < 100) begin
            n++;
            step();
        end
        check("t3_m0_len", 64'(n), 64'(PULSE_LEN - 1));
        for (int i = 1; i < 5; i++) begin
            wait_pulse($sformatf("t3_m%0d", i), m0[i], m1[i], wc, pd);
            check($sformatf("t3_m%0d_wait", i), 64'(wc), 64'(RELAUNCH));
            check($sformatf("t3_m%0d_pend", i), 64'(pd), 64'(exp_pend[i]));
        end
        drain(n);
        step();
        check("t3_no_extra", 64'(o_irq), 64'd0);

        // ---------------- enable gating ----------------
        en = 1'b0;
        push(32'h7777_0007, 32'h7070_7070);
        saw = 1'b0;
        repeat (100) begin
            step();
            if (o_irq) saw = 1'b1;
        end
        check("t4_gated", 64'(saw), 64'd0);
        check("t4_pend", 64'(o_pending), 64'd1);
        check("t4_busy", 64'(o_busy), 64'd0);
        en = 1'b1;
        step();
        check("t4_launch", 64'(o_irq), 64'd1);
        check("t4_r0", 64'(o_irq_r0), 64'h7777_0007);
        en = 1'b0;
        n = 0;
        while (o_irq && n < 100) begin
            n++;
            step();
        end
        check("t4_len_en_low", 64'(n), 64'(PULSE_LEN));
        drain(n);
        check("t4_gap_en_low", 64'(n), 64'(GAP_LEN));

        // ---------------- simultaneous push / pop ----------------
        push(32'hD000_000D, 32'hD1D1_D1D1);
        i_req_valid = 1'b1;
        i_req_r0    = 32'hE000_000E;
        i_req_r1    = 32'hE1E1_E1E1;
        en          = 1'b1;
        step();
        i_req_valid = 1'b0;
        check("t5_irq", 64'(o_irq), 64'd1);
        check("t5_r0_d", 64'(o_irq_r0), 64'hD000_000D);
        check("t5_pend", 64'(o_pending), 64'd1);
        n = 0;
        while (o_irq && n < 100) begin
            n++;
            step();
        end
        wait_pulse("t5_e", 32'hE000_000E, 32'hE1E1_E1E1, wc, pd);
        check("t5_e_wait", 64'(wc), 64'(RELAUNCH));
        check("t5_e_pend", 64'(pd), 64'd0);
        drain(n);

        // ---------------- async reset mid-pulse ----------------
        en = 1'b0;
        push(32'hF000_000F, 32'hF1F1_F1F1);
        push(32'h9000_0009, 32'h9191_9191);
        en = 1'b1;
        step();
        check("t6_launch", 64'(o_irq), 64'd1);
        check("t6_pend", 64'(o_pending), 64'd1);
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_irq", 64'(o_irq), 64'd0);
        check("t6_rst_r0", 64'(o_irq_r0), 64'd0);
        check("t6_rst_r1", 64'(o_irq_r1), 64'd0);
        check("t6_rst_pend", 64'(o_pending), 64'd0);
        check("t6_rst_busy", 64'(o_busy), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_ready", 64'(o_req_ready), 64'd1);
        saw = 1'b0;
        repeat (30) begin
            step();
            if (o_irq) saw = 1'b1;
        end
        check("t6_flushed", 64'(saw), 64'd0);
        check("t6_pend_after", 64'(o_pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
